// File: rtl/cs_resolve_adder_64.sv
// Carry-save resolver: one 3:2 layer followed by a segment-pipelined carry-propagate adder.
// All stages advance together under a single valid/ready enable.
module cs_resolve_adder_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] vec_a_i,
  input  logic [WIDTH-1:0] vec_b_i,
  input  logic [WIDTH-1:0] vec_c_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             busy_o
);

  localparam int unsigned NSEG = WIDTH / SEG;

  logic adv;
  logic in_xfer;

  // v_q[0] is the 3:2 stage, v_q[k] is segment stage k; v_q[NSEG] is valid_o.
  logic [NSEG:0] v_q, v_d;

  // s_q/c_q/cy_q[j]: operands and incoming carry held by stage j (j = 0..NSEG-1).
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] s_d [NSEG];
  logic [WIDTH-1:0] c_q [NSEG];
  logic [WIDTH-1:0] c_d [NSEG];
  logic [NSEG-1:0]  cy_q, cy_d;

  // r_q[j]: resolved low segments held by stage j+1; r_q[NSEG-1] drives sum_o.
  logic [WIDTH-1:0] r_q [NSEG];
  logic [WIDTH-1:0] r_d [NSEG];

  logic [SEG:0] seg_sum [NSEG];
  logic         unused_top_carry;

  assign adv     = ~v_q[NSEG] | ready_i;
  assign ready_o = adv;
  assign in_xfer = valid_i & adv;

  always_comb begin
    for (int unsigned j = 0; j < NSEG; j++) begin
      seg_sum[j] = {1'b0, s_q[j][j*SEG +: SEG]} + {1'b0, c_q[j][j*SEG +: SEG]}
                 + {{SEG{1'b0}}, cy_q[j]};
    end
  end

  assign unused_top_carry = seg_sum[NSEG-1][SEG];

  always_comb begin
    v_d  = v_q;
    s_d  = s_q;
    c_d  = c_q;
    cy_d = cy_q;
    r_d  = r_q;
    if (adv) begin
      v_d = {v_q[NSEG-1:0], in_xfer};
      if (in_xfer) begin
        s_d[0] = vec_a_i ^ vec_b_i ^ vec_c_i;
        c_d[0] = ((vec_a_i & vec_b_i) | (vec_a_i & vec_c_i) | (vec_b_i & vec_c_i)) << 1;
      end
      cy_d[0] = 1'b0;
      r_d[0]  = '0;
      r_d[0][SEG-1:0] = seg_sum[0][SEG-1:0];
      for (int unsigned j = 1; j < NSEG; j++) begin
        s_d[j]  = s_q[j-1];
        c_d[j]  = c_q[j-1];
        cy_d[j] = seg_sum[j-1][SEG];
        r_d[j]  = r_q[j-1];
        r_d[j][j*SEG +: SEG] = seg_sum[j][SEG-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q  <= '0;
      cy_q <= '0;
      for (int unsigned j = 0; j < NSEG; j++) begin
        s_q[j] <= '0;
        c_q[j] <= '0;
        r_q[j] <= '0;
      end
    end else begin
      v_q  <= v_d;
      cy_q <= cy_d;
      for (int unsigned j = 0; j < NSEG; j++) begin
        s_q[j] <= s_d[j];
        c_q[j] <= c_d[j];
        r_q[j] <= r_d[j];
      end
    end
  end

  assign valid_o = v_q[NSEG];
  assign sum_o   = r_q[NSEG-1];
  assign busy_o  = |v_q;

endmodule

// File: tb/tb_cs_resolve_adder_64.sv
// Scoreboard bench: the driver queues expected sums on accept, a negedge monitor pops
// and compares on every output transfer and watches output stability during stalls.
module tb_cs_resolve_adder_64;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [63:0] vec_a_i = '0;
  logic [63:0] vec_b_i = '0;
  logic [63:0] vec_c_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [63:0] sum_o;
  logic        busy_o;

  cs_resolve_adder_64 dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .vec_a_i (vec_a_i),
    .vec_b_i (vec_b_i),
    .vec_c_i (vec_c_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] exp;
    int          acc;
    bit          lat;
  } ent_t;

  ent_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          held = 1'b0;
  logic [63:0] held_val = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid_o & ready_i here.
  always @(negedge clk_i) begin
    ent_t e;
    if (!rst_ni) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", {63'd0, valid_o}, 64'd1);
        chk("stall_hold", sum_o, held_val);
      end
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", sum_o, 64'hxxxx_xxxx_xxxx_xxxx);
        end else begin
          e = sb_q.pop_front();
          chk("sum", sum_o, e.exp);
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd5);
        end
      end
      if (valid_o && !ready_i) begin
        chk("stall_ready", {63'd0, ready_o}, 64'd0);
        held     = 1'b1;
        held_val = sum_o;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [63:0] exp, input bit lat);
    int n = 0;
    bit done = 1'b0;
    valid_i = 1'b1;
    vec_a_i = a;
    vec_b_i = b;
    vec_c_i = c;
    while (!done) begin
      @(negedge clk_i);
      if (ready_o) begin
        sb_q.push_back('{exp: exp, acc: cyc, lat: lat});
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
      n++;
      if (!done && n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
    vec_a_i = 64'hdead_beef_dead_beef;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    #1;
    @(negedge clk_i);
    chk("idle_busy", {63'd0, busy_o}, 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [63:0] a, b, c;

    // Reset values
    rst_ni  = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_sum", sum_o, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(1);

    // Basic, carry chain and segment boundary vectors
    send(64'd1, 64'd2, 64'd3, 64'd6, 1'b1);
    drain();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    send(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_FFFF_0000,
         64'h0000_0001_0000_0000, 1'b0);
    drain();

    // Streaming with backpressure on relative cycles 7-9 and 12
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          c = {$urandom, $urandom};
          send(a, b, c, a + b + c, 1'b0);
        end
      end
      begin
        for (int r = 0; r < 40; r++) begin
          ready_i = !(r inside {7, 8, 9, 12});
          @(posedge clk_i);
          #1;
        end
        ready_i = 1'b1;
      end
    join
    drain();

    // Bubbles with the output blocked from the start
    ready_i = 1'b0;
    send(64'h10, 64'h20, 64'h30, 64'h60, 1'b0);
    idle(1);
    send(64'h1111_2222_3333_4444, 64'd1, 64'd0, 64'h1111_2222_3333_4445, 1'b0);
    idle(1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd7, 64'd7, 1'b0);
    valid_i = 1'b1;
    vec_a_i = 64'h0123_4567_89AB_CDEF;
    vec_b_i = 64'hFEDC_BA98_7654_3210;
    vec_c_i = 64'd1;
    repeat (3) begin
      @(negedge clk_i);
      chk("full_ready", {63'd0, ready_o}, 64'd0);
      chk("full_valid", {63'd0, valid_o}, 64'd1);
      chk("full_head", sum_o, 64'h60);
      @(posedge clk_i);
      #1;
    end
    ready_i = 1'b1;
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'd1, 64'd0, 1'b0);
    drain();

    // Reset mid-flight discards everything in the pipeline
    send(64'd11, 64'd22, 64'd33, 64'd66, 1'b0);
    send(64'd44, 64'd55, 64'd66, 64'd165, 1'b0);
    send(64'd77, 64'd88, 64'd99, 64'd264, 1'b0);
    rst_ni = 1'b0;
    sb_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_valid", {63'd0, valid_o}, 64'd0);
    chk("mid_rst_sum", sum_o, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    @(posedge clk_i);
    #1;
    idle(6);
    send(64'd5, 64'd5, 64'd5, 64'd15, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
